// File: rtl/param_def.sv
// rtl/param_def.sv - shared trellis constants and types for the K=9 radix-4 encoder/decoder pair
package param_def;

  localparam int SREG_W     = 8;
  localparam int K          = SREG_W + 1;
  localparam int RADIX      = 4;
  localparam int SYM_W      = $clog2(RADIX);
  localparam int CODE_W     = 2 * SYM_W;

  localparam logic [K-1:0] G0_DEF = 9'o561;
  localparam logic [K-1:0] G1_DEF = 9'o753;

  // Zero symbols needed to shift every state bit back out to 0.
  localparam int TAIL_SYMS  = SREG_W / SYM_W;
  localparam int TAIL_CNT_W = $clog2(TAIL_SYMS);

  typedef logic [SREG_W-1:0] enc_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_fsm_t;

  function automatic logic tap_parity(input logic [K-1:0] w, input logic [K-1:0] g);
    return ^(w & g);
  endfunction

endpackage

// File: rtl/conv_enc_bit_step.sv
// rtl/conv_enc_bit_step.sv - one trellis bit step: code bits for input b from state s, and successor state
import param_def::*;

module conv_enc_bit_step #(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic [SREG_W-1:0] s,
  input  logic              b,
  output logic              c0,
  output logic              c1,
  output logic [SREG_W-1:0] s_nxt
);

  logic [K-1:0] w;

  // Newest bit sits at window bit 0, oldest state bit at the top.
  assign w     = {s, b};
  assign c0    = tap_parity(w, G0);
  assign c1    = tap_parity(w, G1);
  assign s_nxt = {s[SREG_W-2:0], b};

endmodule

// File: rtl/conv_encoder_r4.sv
// rtl/conv_encoder_r4.sv - radix-4 K=9 rate-1/2 convolutional encoder with valid/ready streams
// Zero-tail flush per frame is built only when CONV_ENC_TAIL_EN is defined.
import param_def::*;

module conv_encoder_r4 #(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_data,
  input  logic              i_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [3:0]        o_sym,
  output logic              o_last,
  output logic [SREG_W-1:0] o_state,
  output logic              o_busy
);

`ifdef CONV_ENC_TAIL_EN
  localparam logic TAIL_EN = 1'b1;
`else
  localparam logic TAIL_EN = 1'b0;
`endif

  localparam logic [TAIL_CNT_W-1:0] TAIL_LAST = TAIL_CNT_W'(TAIL_SYMS - 1);

  enc_fsm_t                fsm;
  enc_fsm_t                fsm_nxt;
  logic [SREG_W-1:0]       s;
  logic [SREG_W-1:0]       s_mid;
  logic [SREG_W-1:0]       s_nxt;
  logic [TAIL_CNT_W-1:0]   tail_cnt;
  logic [SYM_W-1:0]        u;
  logic                    c0a, c1a, c0b, c1b;
  logic [CODE_W-1:0]       sym_nxt;
  logic                    out_free;
  logic                    accept;
  logic                    tail_issue;
  logic                    tail_done;
  logic                    frame_clear;

  assign out_free    = !o_valid || i_ready;
  assign o_ready     = (fsm != TAIL) && out_free;
  assign accept      = i_valid && o_ready;
  assign tail_issue  = (fsm == TAIL) && out_free;
  assign tail_done   = tail_issue && (tail_cnt == TAIL_LAST);
  // Without the tail, the state is zeroed directly at the last data symbol.
  assign frame_clear = accept && i_last && !TAIL_EN;
  assign o_busy      = (fsm != IDLE);

  assign u = (fsm == TAIL) ? '0 : i_data;

  // u[0] enters the register first so the state ordering matches the decoder trellis.
  conv_enc_bit_step #(.G0(G0), .G1(G1)) u_step_a (
    .s     (s),
    .b     (u[0]),
    .c0    (c0a),
    .c1    (c1a),
    .s_nxt (s_mid)
  );

  conv_enc_bit_step #(.G0(G0), .G1(G1)) u_step_b (
    .s     (s_mid),
    .b     (u[1]),
    .c0    (c0b),
    .c1    (c1b),
    .s_nxt (s_nxt)
  );

  assign sym_nxt = {c0a, c1a, c0b, c1b};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_nxt;
    end
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE: begin
        if (accept) begin
          if (i_last) fsm_nxt = TAIL_EN ? TAIL : IDLE;
          else        fsm_nxt = DATA;
        end
      end
      DATA: begin
        if (accept && i_last) fsm_nxt = TAIL_EN ? TAIL : IDLE;
      end
      TAIL: begin
        if (tail_done) fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s        <= '0;
      tail_cnt <= '0;
      o_valid  <= 1'b0;
      o_sym    <= '0;
      o_last   <= 1'b0;
      o_state  <= '0;
    end else begin
      if (accept || tail_issue) begin
        o_valid <= 1'b1;
        o_sym   <= sym_nxt;
        o_state <= s_nxt;
        o_last  <= accept ? (i_last && !TAIL_EN) : tail_done;
        s       <= frame_clear ? '0 : s_nxt;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
      if (tail_issue) begin
        tail_cnt <= tail_done ? '0 : tail_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder_r4.sv
// tb/tb_conv_encoder_r4.sv - randomized bench for conv_encoder_r4 against a bit-serial parity model
module tb_conv_encoder_r4;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic       o_ready;
  logic [1:0] i_data;
  logic       i_last;
  logic       o_valid;
  logic       i_ready;
  logic [3:0] o_sym;
  logic       o_last;
  logic [7:0] o_state;
  logic       o_busy;

  conv_encoder_r4 dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sym   (o_sym),
    .o_last  (o_last),
    .o_state (o_state),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sym;
    logic       last;
    logic [7:0] st;
  } exp_t;

  exp_t q[$];
  int   ref_s;
  int   checks   = 0;
  int   failures = 0;
  bit   last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift-register encoder: window is the 9-bit history with the newest bit at position 0.
  function automatic logic [1:0] bit_code(inout int s, input int b);
    int w;
    w = ((s << 1) | b) & 'h1ff;
    bit_code = {1'($countones(w & 'o561)), 1'($countones(w & 'o753))};
    s = w & 'hff;
  endfunction

  function automatic exp_t enc_symbol(input int u);
    exp_t e;
    int   s = ref_s;
    logic [1:0] a, b;
    a = bit_code(s, u & 1);
    b = bit_code(s, (u >> 1) & 1);
    e.sym  = {a, b};
    e.st   = 8'(s);
    e.last = 1'b0;
    ref_s  = s;
    return e;
  endfunction

  task automatic ref_push(input int u, input logic last);
    exp_t e;
    e = enc_symbol(u);
`ifdef CONV_ENC_TAIL_EN
    q.push_back(e);
    if (last) begin
      for (int k = 0; k < 4; k++) begin
        e = enc_symbol(0);
        e.last = (k == 3);
        q.push_back(e);
      end
    end
`else
    e.last = last;
    q.push_back(e);
    if (last) ref_s = 0;
`endif
  endtask

  // Called at a negedge with inputs set: score the upcoming edge, then advance one cycle.
  task automatic clk_step();
    exp_t e;
    #1;
    if (o_valid && i_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = q.pop_front();
        chk("sym", o_sym, e.sym);
        chk("last", o_last, e.last);
        chk("state", o_state, e.st);
      end
    end
    last_acc = i_valid && o_ready;
    if (last_acc) ref_push(i_data, i_last);
    @(negedge clk);
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int n = 0; n < 40 && (q.size() > 0 || o_valid); n++) clk_step();
    chk("drain_done", (q.size() == 0 && !o_valid), 1);
  endtask

  logic [3:0] snap_sym;
  logic [7:0] snap_st;
  int         sent;

  initial begin
    rst = 1'b0; i_valid = 1'b0; i_data = 2'b00; i_last = 1'b0; i_ready = 1'b0;
    ref_s = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_sym", o_sym, 0);
    chk("rst_last", o_last, 0);
    chk("rst_state", o_state, 0);
    chk("rst_busy", o_busy, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single-symbol frame u=01 from state 0.
    i_valid = 1'b1; i_data = 2'b01; i_last = 1'b1; i_ready = 1'b1;
    clk_step();
    i_valid = 1'b0;
    chk("t1_valid", o_valid, 1);
    chk("t1_sym", o_sym, 4'b1101);
    chk("t1_state", o_state, 8'h02);
`ifdef CONV_ENC_TAIL_EN
    chk("t1_last", o_last, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("tail_ready", o_ready, 0);
      chk("tail_busy", o_busy, 1);
      clk_step();
    end
    chk("tail_last", o_last, 1);
    chk("tail_state", o_state, 0);
    chk("tail_busy_end", o_busy, 0);
`else
    chk("t1_last", o_last, 1);
    chk("t1_busy", o_busy, 0);
`endif
    drain();

    // All-zero stream at full throughput.
    i_valid = 1'b1; i_data = 2'b00; i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i_last = (k == 7);
      #1;
      chk("zero_ready", o_ready, 1);
      if (k > 0) begin
        chk("zero_valid", o_valid, 1);
        chk("zero_sym", o_sym, 0);
        chk("zero_state", o_state, 0);
      end
      clk_step();
    end
    i_last = 1'b0;
    drain();

    // Backpressure mid-frame; inputs offered while stalled must be ignored.
    i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_data = 2'($urandom);
      clk_step();
    end
    i_ready = 1'b0;
    #1;
    snap_sym = o_sym;
    snap_st  = o_state;
    for (int k = 0; k < 3; k++) begin
      i_data = 2'($urandom);
      #1;
      chk("bp_ready", o_ready, 0);
      clk_step();
      chk("bp_valid", o_valid, 1);
      chk("bp_sym_hold", o_sym, snap_sym);
      chk("bp_state_hold", o_state, snap_st);
    end
    i_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_data = 2'($urandom);
      i_last = (k == 4);
      clk_step();
    end
    i_last = 1'b0;
    drain();

    // Random 64-symbol frame with random valid and ready.
    sent = 0;
    for (int n = 0; n < 3000 && sent < 64; n++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = 2'($urandom);
      i_ready = ($urandom_range(0, 3) != 0);
      i_last  = (sent == 63);
      clk_step();
      if (last_acc) sent++;
    end
    chk("rand_sent", sent, 64);
    i_last = 1'b0;
    drain();

    // Asynchronous reset in the middle of a frame (during the tail when built with it).
    i_valid = 1'b1; i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_data = 2'($urandom);
`ifdef CONV_ENC_TAIL_EN
      i_last = (k == 2);
`else
      i_last = 1'b0;
`endif
      clk_step();
    end
    i_valid = 1'b0; i_last = 1'b0;
    clk_step();
    rst = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_sym", o_sym, 0);
    chk("arst_last", o_last, 0);
    chk("arst_state", o_state, 0);
    chk("arst_busy", o_busy, 0);
    q.delete();
    ref_s = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    i_valid = 1'b1; i_data = 2'b01; i_last = 1'b1;
    clk_step();
    i_valid = 1'b0; i_last = 1'b0;
    chk("post_rst_sym", o_sym, 4'b1101);
    chk("post_rst_state", o_state, 8'h02);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
